// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder driver: FSM states,
// counter sizing helper and output reset values.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_ADDER_LAT = 1;

    // Counter spans SHIFT plus DRAIN: 0 .. WIDTH+ADDER_LAT-1
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned lat);
        return $clog2(width + lat + 1);
    endfunction

    localparam int unsigned DEF_CNT_W = cnt_width(DEF_WIDTH, DEF_ADDER_LAT);

    localparam logic RST_IN_READY  = 1'b1;
    localparam logic RST_OUT_VALID = 1'b0;
    localparam logic RST_SER       = 1'b0;
    localparam logic RST_COUT      = 1'b0;
    localparam logic RST_ERR       = 1'b0;

endpackage

// File: rtl/serial_add_driver_if.sv
// Parallel operand/result handshakes and serial adder lines of serial_add_driver.
// master = the driver block, slave = its environment (datapath + serial adder).
interface serial_add_driver_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ser_a;
    logic             ser_b;
    logic             ser_cin;
    logic             ser_first;
    logic             ser_sum;
    logic             ser_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             err;

    modport master (
        input  in_valid, a, b, cin, ser_sum, ser_cout, out_ready,
        output in_ready, ser_a, ser_b, ser_cin, ser_first, out_valid, sum, cout, err
    );

    modport slave (
        output in_valid, a, b, cin, ser_sum, ser_cout, out_ready,
        input  in_ready, ser_a, ser_b, ser_cin, ser_first, out_valid, sum, cout, err
    );

endinterface

// File: rtl/serial_shift_reg.sv
// WIDTH-bit right shift register with parallel load; serial data enters at
// the MSB and leaves from the LSB.
module serial_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift_en,
    input  logic             i_ser_in,
    output logic             o_ser_out,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_data;
        end else if (i_shift_en) begin
            r_q <= {i_ser_in, r_q[WIDTH-1:1]};
        end
    end

    assign o_ser_out = r_q[0];
    assign o_q       = r_q;

endmodule

// File: rtl/serial_add_driver.sv
// Bit-serial transmit/collect controller for a clocked serial full adder.
// Optional SELF_CHECK_EN: compares the collected result with a reference adder.
module serial_add_driver
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ADDER_LAT = DEF_ADDER_LAT
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_add_driver_if.master bus
);

    localparam int unsigned     CNT_W      = cnt_width(WIDTH, ADDER_LAT);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(WIDTH + ADDER_LAT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cin;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_accept;
    logic             w_busy;
    logic             w_sample;
    logic             w_last;
    logic             w_a_ser;
    logic             w_b_ser;
    logic             w_sum_ser_out;
    logic [WIDTH-1:0] w_a_q;
    logic [WIDTH-1:0] w_b_q;
    logic [WIDTH-1:0] w_sum_q;
    logic             w_unused;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = RST_OUT_VALID;
        bus.ser_a     = RST_SER;
        bus.ser_b     = RST_SER;
        bus.ser_cin   = RST_SER;
        bus.ser_first = RST_SER;
        case (r_state)
            IDLE: begin
                bus.in_ready = RST_IN_READY;
                if (bus.in_valid) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                bus.ser_a = w_a_ser;
                bus.ser_b = w_b_ser;
                if (r_cnt == '0) begin
                    bus.ser_first = 1'b1;
                    bus.ser_cin   = r_cin;
                end
                if (r_cnt == SHIFT_LAST) w_state_nxt = (ADDER_LAT > 0) ? DRAIN : DONE;
            end
            DRAIN: begin
                if (r_cnt == LAST_CNT) w_state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_busy   = (r_state == SHIFT) || (r_state == DRAIN);
    assign w_last   = w_busy && (r_cnt == LAST_CNT);

    // Sum bit i returns ADDER_LAT cycles after it was driven
    generate
        if (ADDER_LAT == 0) begin : g_sample_nolat
            assign w_sample = w_busy;
        end else begin : g_sample_lat
            assign w_sample = w_busy && (r_cnt >= CNT_W'(ADDER_LAT));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_cin <= RST_SER;
        end else begin
            r_cnt <= w_busy ? r_cnt + CNT_W'(1) : '0;
            if (w_accept) r_cin <= bus.cin;
        end
    end

    // Output copy is taken on the final sample so sum stays stable while the next operation shifts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= RST_COUT;
        end else if (w_last) begin
            r_sum  <= {bus.ser_sum, w_sum_q[WIDTH-1:1]};
            r_cout <= bus.ser_cout;
        end
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

    serial_shift_reg #(.WIDTH(WIDTH)) u_piso_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_accept),
        .i_load_data (bus.a),
        .i_shift_en  (r_state == SHIFT),
        .i_ser_in    (1'b0),
        .o_ser_out   (w_a_ser),
        .o_q         (w_a_q)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_piso_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_accept),
        .i_load_data (bus.b),
        .i_shift_en  (r_state == SHIFT),
        .i_ser_in    (1'b0),
        .o_ser_out   (w_b_ser),
        .o_q         (w_b_q)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_sipo_sum (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_accept),
        .i_load_data ('0),
        .i_shift_en  (w_sample),
        .i_ser_in    (bus.ser_sum),
        .o_ser_out   (w_sum_ser_out),
        .o_q         (w_sum_q)
    );

    assign w_unused = ^{w_a_q, w_b_q, w_sum_ser_out, w_sum_q[0]};

`ifdef SELF_CHECK_EN
    logic [WIDTH:0] r_ref;
    logic           r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref <= '0;
            r_err <= RST_ERR;
        end else begin
            if (w_accept) r_ref <= {1'b0, bus.a} + {1'b0, bus.b} + (WIDTH + 1)'(bus.cin);
            if (w_last && ({bus.ser_cout, bus.ser_sum, w_sum_q[WIDTH-1:1]} != r_ref)) r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = RST_ERR;
`endif

endmodule

// File: tb/tb_serial_add_driver.sv
// Directed bench for serial_add_driver (WIDTH=8, ADDER_LAT=1) with a
// behavioural one-cycle-latency serial full adder on the serial lines.
module tb_serial_add_driver;

`ifdef SELF_CHECK_EN
    localparam logic [31:0] EXP_ERR = 32'd1;
`else
    localparam logic [31:0] EXP_ERR = 32'd0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_add_driver_if #(.WIDTH(8)) bus ();

    serial_add_driver #(.WIDTH(8), .ADDER_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks  = 0;
    int   errors  = 0;
    logic corrupt = 1'b0;
    logic m_carry = 1'b0;
    int   m_idx   = 0;

    // Serial full adder: registered sum/carry, bit 0 takes ser_cin instead of stored carry
    always @(posedge clk) begin : adder_model
        logic cin_eff;
        logic s;
        logic c;
        int   idx;
        cin_eff = bus.ser_first ? bus.ser_cin : m_carry;
        s   = bus.ser_a ^ bus.ser_b ^ cin_eff;
        c   = (bus.ser_a & bus.ser_b) | (bus.ser_a & cin_eff) | (bus.ser_b & cin_eff);
        idx = bus.ser_first ? 0 : m_idx;
        if (corrupt && idx == 3) s = ~s;
        bus.ser_sum  <= s;
        bus.ser_cout <= c;
        m_carry      <= c;
        m_idx        <= idx + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(output int lat, output int firsts, output int stray, output logic cin_first);
        lat       = 0;
        firsts    = 0;
        stray     = 0;
        cin_first = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.ser_first) begin
                firsts++;
                cin_first = bus.ser_cin;
            end else if (bus.ser_cin) begin
                stray++;
            end
            tick();
            lat++;
        end
    endtask

    initial begin
        int   lat;
        int   firsts;
        int   stray;
        logic cin_first;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum",       32'(bus.sum),       32'h00);
        check("rst_cout",      32'(bus.cout),      32'd0);
        check("rst_ser_first", 32'(bus.ser_first), 32'd0);
        check("rst_err",       32'(bus.err),       32'd0);

        send(8'h5A, 8'h33, 1'b0);
        collect(lat, firsts, stray, cin_first);
        check("t1_latency",  32'(lat),    32'd9);
        check("t1_first",    32'(firsts), 32'd1);
        check("t1_cin_stray", 32'(stray), 32'd0);
        check("t1_sum",      32'(bus.sum),  32'h8D);
        check("t1_cout",     32'(bus.cout), 32'd0);
        check("t1_err",      32'(bus.err),  32'd0);
        tick();
        check("t1_idle_ready", 32'(bus.in_ready),  32'd1);
        check("t1_idle_valid", 32'(bus.out_valid), 32'd0);

        send(8'hFF, 8'h01, 1'b1);
        collect(lat, firsts, stray, cin_first);
        check("t2_latency",   32'(lat),       32'd9);
        check("t2_first",     32'(firsts),    32'd1);
        check("t2_cin_first", 32'(cin_first), 32'd1);
        check("t2_cin_stray", 32'(stray),     32'd0);
        check("t2_sum",       32'(bus.sum),   32'h01);
        check("t2_cout",      32'(bus.cout),  32'd1);
        tick();

        bus.out_ready = 1'b0;
        send(8'h5A, 8'h33, 1'b0);
        collect(lat, firsts, stray, cin_first);
        check("bp_latency", 32'(lat), 32'd9);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 8'(i + 1);
            bus.b        = 8'hC3;
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
            check("bp_sum_held",  32'(bus.sum),       32'h8D);
            check("bp_cout_held", 32'(bus.cout),      32'd0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_release_valid", 32'(bus.out_valid), 32'd1);
        tick();
        check("bp_idle_ready", 32'(bus.in_ready),  32'd1);
        check("bp_idle_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("bp_no_accept", 32'(bus.in_ready), 32'd1);
        check("bp_sum_kept",  32'(bus.sum),      32'h8D);

        send(8'h77, 8'h11, 1'b0);
        repeat (4) tick();
        check("mid_ser_a_live", 32'(bus.ser_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_in_ready",  32'(bus.in_ready),  32'd1);
        check("mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_ser_first", 32'(bus.ser_first), 32'd0);
        check("mid_ser_a",     32'(bus.ser_a),     32'd0);
        check("mid_ser_b",     32'(bus.ser_b),     32'd0);
        check("mid_ser_cin",   32'(bus.ser_cin),   32'd0);
        check("mid_sum",       32'(bus.sum),       32'h00);
        check("mid_cout",      32'(bus.cout),      32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_no_output", 32'(bus.out_valid), 32'd0);
        send(8'h10, 8'h20, 1'b0);
        collect(lat, firsts, stray, cin_first);
        check("mid_next_latency", 32'(lat),      32'd9);
        check("mid_next_sum",     32'(bus.sum),  32'h30);
        check("mid_next_cout",    32'(bus.cout), 32'd0);
        tick();

        corrupt = 1'b1;
        send(8'h01, 8'h02, 1'b0);
        collect(lat, firsts, stray, cin_first);
        corrupt = 1'b0;
        check("sc_bad_sum", 32'(bus.sum), 32'h0B);
        check("sc_err_set", 32'(bus.err), EXP_ERR);
        tick();
        send(8'h03, 8'h04, 1'b0);
        collect(lat, firsts, stray, cin_first);
        check("sc_good_sum",   32'(bus.sum), 32'h07);
        check("sc_err_sticky", 32'(bus.err), EXP_ERR);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
